fpu_share_arbiter: RTL
======================

Name: fpu_share_arbiter

Overview:
- Shares one fpu instance (input register plus fpu_core pipeline) between NUM_REQ requesters, e.g. cores in a cluster.
- Arbitrates requests round-robin and drives the selected operands, rounding mode and opcode into the FPU.
- Tracks each in-flight operation's requester ID in a tag pipeline matched to the FPU latency.
- Routes the result and flags back as a one-cycle valid to the originating requester.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
OP_WIDTH, 32, operand/result width
RM_WIDTH, 3, rounding-mode width
CMD_WIDTH, 4, opcode width
LATENCY, 2, cycles from issue to FPU result, counted in non-stalled cycles (>=1)

Ports:
Clk_CI  in  1  clock
Rst_RBI  in  1  asynchronous reset, active low
Stall_SI  in  1  global stall; freezes arbitration, FPU and tag pipeline
Req_SI  in  NUM_REQ  per-requester request
Operand_a_DI  in  NUM_REQ*OP_WIDTH  operand A, requester i at slice i
Operand_b_DI  in  NUM_REQ*OP_WIDTH  operand B
RM_SI  in  NUM_REQ*RM_WIDTH  rounding mode
OP_SI  in  NUM_REQ*CMD_WIDTH  opcode
Gnt_SO  out  NUM_REQ  one-hot grant; request consumed this cycle
Valid_SO  out  NUM_REQ  one-hot result-valid pulse to owner
Result_DO  out  OP_WIDTH  result, broadcast
Flags_SO  out  6  {OF,UF,Zero,IX,IV,Inf}, broadcast
Idle_SO  out  1  no operation in flight
FpuOperand_a_DO  out  OP_WIDTH  to FPU
FpuOperand_b_DO  out  OP_WIDTH  to FPU
FpuRM_SO  out  RM_WIDTH  to FPU
FpuOP_SO  out  CMD_WIDTH  to FPU
FpuEnable_SO  out  1  to FPU Enable
FpuStall_SO  out  1  to FPU Stall (= Stall_SI)
FpuResult_DI  in  OP_WIDTH  from FPU
FpuFlags_DI  in  6  from FPU {OF,UF,Zero,IX,IV,Inf}

Behaviour:
- Reset:
  - Round-robin pointer = 0; all tag stages invalid.
  - Gnt_SO = 0; Valid_SO = 0; Idle_SO = 1.
  - Reset mid-operation discards all in-flight ops; stale FPU outputs never raise Valid_SO.
- Arbitration (combinational):
  - If Stall_SI = 0 and any Req_SI bit is set, grant the first set bit searching from pointer upward, wrapping at NUM_REQ-1 to 0.
  - Issue = |Gnt_SO. At most one grant per cycle.
  - If Stall_SI = 1, Gnt_SO = 0 and the pointer holds.
- Pointer update:
  - On issue to index k, pointer <= (k+1) mod NUM_REQ.
  - With no issue, pointer holds.
- Handshake:
  - Req_SI and the requester's operands must remain stable until Gnt_SO.
  - A requester holding Req_SI high after a grant issues a new operation. A single requester may issue every cycle.
- FPU drive:
  - On issue, the Fpu* outputs carry the granted requester's slices and FpuEnable_SO = 1.
  - With no issue, the Fpu* data outputs are 0 and FpuEnable_SO = 0.
  - FpuStall_SO = Stall_SI.
- Tag pipeline:
  - LATENCY stages of {valid, id}.
  - Stage 0 loads {issue, granted index}; stages shift one per cycle when Stall_SI = 0 and all hold when Stall_SI = 1.
- Result return:
  - Valid_SO[id_tail] = valid_tail & ~Stall_SI; a stalled result is delivered on the first unstalled cycle, exactly once.
  - Result_DO = FpuResult_DI and Flags_SO = FpuFlags_DI, unregistered and meaningful only while some Valid_SO bit is set.
  - Results return in issue order.
  - Total latency: Gnt at cycle t -> Valid at t+LATENCY with no stalls; each stall cycle adds one.
- Idle_SO = 1 when no tag stage is valid; it is combinational and does not count the issuing cycle.
- Simultaneous issue and retire in the same cycle is normal full-throughput operation: one op in, one op out.
- Only NUM_REQ and LATENCY are structural. LATENCY must match the instantiated FPU pipeline.

Test Plan:
- Reset then single request: Req_SI=4'b0010, A=0x3F800000, B=0x40000000, OP=add.
  - Gnt_SO=0010 in the same cycle.
  - Valid_SO=0010 exactly 2 cycles later with Result_DO=0x40400000.
  - Idle_SO=1 again the following cycle.
- All four requesters hold Req_SI=1111 for 8 cycles:
  - Grants in order 0001,0010,0100,1000,0001,... (one per cycle).
  - Valid_SO sequence is identical, delayed 2 cycles.
- Stall during flight: issue to req 2, assert Stall_SI for 3 cycles starting the next cycle.
  - No grants during the stall.
  - Valid_SO=0100 appears at issue+5, as a single pulse.
- Pointer wrap and fairness: pointer at 3 after a grant to 2, with Req_SI=1001.
  - Grant 1000, then 0001.
  - Next with Req_SI=1001, grant 1000 again.
- Reset mid-operation: issue to reqs 0 and 1 on consecutive cycles, then assert Rst_RBI low one cycle later.
  - Valid_SO stays 0 after reset release.
  - Pointer = 0; a new Req_SI=1111 grants 0001.
- Stall with a result at the tail: Stall_SI=1 for 2 cycles while tail valid (id 3).
  - Valid_SO=0 during the stall.
  - Valid_SO=1000 for exactly one cycle after release, with Result_DO matching the expected value.

Source files
------------

// File: rtl/fpu_share_arbiter_if.sv
// ----------------------------------------------------------------------------
// fpu_share_arbiter_if
// Requester-side bus of the shared-FPU arbiter. All requesters are packed
// side by side: requester i owns slice i of every per-requester vector.
//
//   Req_SI        per-requester request
//   Operand_a_DI  operand A slices       Operand_b_DI  operand B slices
//   RM_SI         rounding-mode slices   OP_SI         opcode slices
//   Gnt_SO        one-hot grant (request consumed this cycle)
//   Valid_SO      one-hot result-valid pulse to the owner
//   Result_DO     result, broadcast      Flags_SO      {OF,UF,Zero,IX,IV,Inf}
//
// master: the requester cluster side. slave: the arbiter.
// ----------------------------------------------------------------------------
interface fpu_share_arbiter_if #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned RM_WIDTH  = 3,
  parameter int unsigned CMD_WIDTH = 4
);
  logic [NUM_REQ-1:0]           Req_SI;
  logic [NUM_REQ*OP_WIDTH-1:0]  Operand_a_DI;
  logic [NUM_REQ*OP_WIDTH-1:0]  Operand_b_DI;
  logic [NUM_REQ*RM_WIDTH-1:0]  RM_SI;
  logic [NUM_REQ*CMD_WIDTH-1:0] OP_SI;
  logic [NUM_REQ-1:0]           Gnt_SO;
  logic [NUM_REQ-1:0]           Valid_SO;
  logic [OP_WIDTH-1:0]          Result_DO;
  logic [5:0]                   Flags_SO;

  modport master (
    output Req_SI, Operand_a_DI, Operand_b_DI, RM_SI, OP_SI,
    input  Gnt_SO, Valid_SO, Result_DO, Flags_SO
  );

  modport slave (
    input  Req_SI, Operand_a_DI, Operand_b_DI, RM_SI, OP_SI,
    output Gnt_SO, Valid_SO, Result_DO, Flags_SO
  );
endinterface

// File: rtl/fpu_share_arbiter.sv
// ----------------------------------------------------------------------------
// fpu_share_arbiter
// Shares one pipelined FPU between NUM_REQ requesters. A round-robin
// arbiter picks one request per cycle and drives its operands into the FPU;
// a {valid, id} tag pipeline of depth LATENCY follows each operation so the
// FPU result can be handed back as a one-cycle valid to its owner.
//
// Ports:
//   Clk_CI, Rst_RBI   clock, asynchronous active-low reset
//   Stall_SI          global stall: freezes arbitration, FPU and tags
//   req_bus           requester bus (fpu_share_arbiter_if.slave)
//   Idle_SO           no operation in flight
//   Fpu*_DO/_SO       operands, rounding mode, opcode, enable, stall to FPU
//   FpuResult_DI      result from FPU
//   FpuFlags_DI       flags from FPU {OF,UF,Zero,IX,IV,Inf}
// ----------------------------------------------------------------------------
module fpu_share_arbiter #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned OP_WIDTH  = 32,
  parameter int unsigned RM_WIDTH  = 3,
  parameter int unsigned CMD_WIDTH = 4,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  Stall_SI,
  fpu_share_arbiter_if.slave    req_bus,
  output logic                  Idle_SO,
  output logic [OP_WIDTH-1:0]   FpuOperand_a_DO,
  output logic [OP_WIDTH-1:0]   FpuOperand_b_DO,
  output logic [RM_WIDTH-1:0]   FpuRM_SO,
  output logic [CMD_WIDTH-1:0]  FpuOP_SO,
  output logic                  FpuEnable_SO,
  output logic                  FpuStall_SO,
  input  logic [OP_WIDTH-1:0]   FpuResult_DI,
  input  logic [5:0]            FpuFlags_DI
);

  localparam int unsigned ID_WIDTH = $clog2(NUM_REQ);
  localparam logic [ID_WIDTH:0]   NUM_REQ_EXT = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID     = ID_WIDTH'(NUM_REQ - 1);

  logic [ID_WIDTH-1:0] ptr_q;
  logic [ID_WIDTH-1:0] ptr_nxt;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_WIDTH-1:0] gnt_idx;
  logic                issue;
  logic                found;
  logic [ID_WIDTH:0]   cand_ext;
  logic [ID_WIDTH-1:0] cand;

  logic [LATENCY-1:0]  tag_vld_q;
  logic [ID_WIDTH-1:0] tag_id_q [LATENCY];
  logic [NUM_REQ-1:0]  valid;

  // Round-robin search starting at the pointer and wrapping past NUM_REQ-1.
  // NOTE: blocking assignments in combinational logic: 'found' must be seen
  // by later loop iterations within the same evaluation. Every variable is
  // defaulted first so no path can infer a latch.
  always_comb begin
    gnt      = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    cand_ext = '0;
    cand     = '0;
    if (!Stall_SI) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        cand_ext = {1'b0, ptr_q} + (ID_WIDTH+1)'(i);
        if (cand_ext >= NUM_REQ_EXT) cand_ext = cand_ext - NUM_REQ_EXT;
        cand = cand_ext[ID_WIDTH-1:0];
        if (!found && req_bus.Req_SI[cand]) begin
          found     = 1'b1;
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  assign issue   = |gnt;
  assign ptr_nxt = (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value regardless of block ordering.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr_q <= '0;
    end else if (issue) begin
      ptr_q <= ptr_nxt;
    end
  end

  // Operand mux: AND-OR style on the one-hot grant, so an idle cycle
  // drives zeros into the FPU.
  always_comb begin
    FpuOperand_a_DO = '0;
    FpuOperand_b_DO = '0;
    FpuRM_SO        = '0;
    FpuOP_SO        = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        FpuOperand_a_DO = req_bus.Operand_a_DI[i*OP_WIDTH +: OP_WIDTH];
        FpuOperand_b_DO = req_bus.Operand_b_DI[i*OP_WIDTH +: OP_WIDTH];
        FpuRM_SO        = req_bus.RM_SI[i*RM_WIDTH +: RM_WIDTH];
        FpuOP_SO        = req_bus.OP_SI[i*CMD_WIDTH +: CMD_WIDTH];
      end
    end
  end

  assign FpuEnable_SO = issue;
  assign FpuStall_SO  = Stall_SI;

  // Tag valids are reset so a reset mid-flight discards every operation and
  // stale FPU outputs can never raise a valid.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      tag_vld_q <= '0;
    end else if (!Stall_SI) begin
      tag_vld_q[0] <= issue;
      for (int unsigned i = 1; i < LATENCY; i++) tag_vld_q[i] <= tag_vld_q[i-1];
    end
  end

  // NOTE: the id array carries no reset: an id is only ever read when its
  // valid bit is set, and the valid bits are reset above.
  always_ff @(posedge Clk_CI) begin
    if (!Stall_SI) begin
      tag_id_q[0] <= gnt_idx;
      for (int unsigned i = 1; i < LATENCY; i++) tag_id_q[i] <= tag_id_q[i-1];
    end
  end

  // A stalled tail holds in place and is delivered on the first unstalled
  // cycle, then shifts out, so it is reported exactly once.
  always_comb begin
    valid = '0;
    if (tag_vld_q[LATENCY-1] && !Stall_SI) valid[tag_id_q[LATENCY-1]] = 1'b1;
  end

  assign req_bus.Gnt_SO    = gnt;
  assign req_bus.Valid_SO  = valid;
  assign req_bus.Result_DO = FpuResult_DI;
  assign req_bus.Flags_SO  = FpuFlags_DI;
  assign Idle_SO           = ~|tag_vld_q;

endmodule
